// File: rtl/ps2_kbd_ctrl.sv
// PS/2 keyboard scancode controller: pops bytes from the receiver FIFO, folds
// E0/F0 prefixes into key events, tracks the held key and counts presses.
module ps2_kbd_ctrl #(
  parameter bit TYPEMATIC_FILTER = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] kbd_data,
  input  logic       kbd_ready,
  input  logic       kbd_overflow,
  input  logic       clr_ovf,
  output logic       kbd_nextdata_n,
  output logic       key_valid,
  output logic [7:0] key_code,
  output logic       key_release,
  output logic       key_ext,
  output logic [7:0] press_count,
  output logic       held_valid,
  output logic [7:0] held_code,
  output logic       ovf_sticky
);

  // state  | meaning
  // IDLE   | wait for kbd_ready, latch FIFO head byte
  // ACK    | pop strobe low for one cycle
  // DECODE | interpret latched byte, emit event; FIFO flags settle meanwhile
  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACK    = 2'd1,
    S_DECODE = 2'd2
  } state_e;

  localparam logic [7:0] BYTE_BRK = 8'hF0;
  localparam logic [7:0] BYTE_EXT = 8'hE0;
  localparam logic [7:0] BYTE_NUL = 8'h00;
  localparam logic [7:0] BYTE_ERR = 8'hFF;

  state_e     state_q, state_d;
  logic [7:0] byte_q, byte_d;
  logic       brk_q, brk_d;
  logic       ext_q, ext_d;
  logic       nextdata_n_q, nextdata_n_d;
  logic       key_valid_q, key_valid_d;
  logic [7:0] key_code_q, key_code_d;
  logic       key_release_q, key_release_d;
  logic       key_ext_q, key_ext_d;
  logic [7:0] press_count_q, press_count_d;
  logic       held_valid_q, held_valid_d;
  logic [7:0] held_code_q, held_code_d;
  logic       held_ext_q, held_ext_d;
  logic       ovf_q, ovf_d;

  logic       held_match;
  logic       typematic_hit;

  assign held_match    = held_valid_q && (held_ext_q == ext_q) && (held_code_q == byte_q);
  assign typematic_hit = TYPEMATIC_FILTER && !brk_q && held_match;

  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (kbd_ready) state_d = S_ACK;
      S_ACK:    state_d = S_DECODE;
      S_DECODE: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_comb begin
    byte_d        = byte_q;
    brk_d         = brk_q;
    ext_d         = ext_q;
    nextdata_n_d  = 1'b1;
    key_valid_d   = 1'b0;
    key_code_d    = key_code_q;
    key_release_d = key_release_q;
    key_ext_d     = key_ext_q;
    press_count_d = press_count_q;
    held_valid_d  = held_valid_q;
    held_code_d   = held_code_q;
    held_ext_d    = held_ext_q;

    case (state_q)
      S_IDLE: begin
        if (kbd_ready) begin
          byte_d       = kbd_data;
          nextdata_n_d = 1'b0;
        end
      end
      S_DECODE: begin
        if (byte_q == BYTE_BRK) begin
          brk_d = 1'b1;
        end else if (byte_q == BYTE_EXT) begin
          ext_d = 1'b1;
        end else if (byte_q == BYTE_NUL || byte_q == BYTE_ERR) begin
          brk_d = 1'b0;
          ext_d = 1'b0;
        end else begin
          brk_d = 1'b0;
          ext_d = 1'b0;
          if (!typematic_hit) begin
            key_valid_d   = 1'b1;
            key_code_d    = byte_q;
            key_release_d = brk_q;
            key_ext_d     = ext_q;
            if (!brk_q) begin
              held_valid_d  = 1'b1;
              held_code_d   = byte_q;
              held_ext_d    = ext_q;
              press_count_d = press_count_q + 8'd1;
            end else if (held_match) begin
              held_valid_d = 1'b0;
            end
          end
        end
      end
      default: ;
    endcase
  end

  // Overflow set has priority over a simultaneous clear so no event is lost.
  always_comb begin
    ovf_d = ovf_q;
    if (kbd_overflow)  ovf_d = 1'b1;
    else if (clr_ovf)  ovf_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      byte_q        <= 8'h00;
      brk_q         <= 1'b0;
      ext_q         <= 1'b0;
      nextdata_n_q  <= 1'b1;
      key_valid_q   <= 1'b0;
      key_code_q    <= 8'h00;
      key_release_q <= 1'b0;
      key_ext_q     <= 1'b0;
      press_count_q <= 8'h00;
      held_valid_q  <= 1'b0;
      held_code_q   <= 8'h00;
      held_ext_q    <= 1'b0;
      ovf_q         <= 1'b0;
    end else begin
      byte_q        <= byte_d;
      brk_q         <= brk_d;
      ext_q         <= ext_d;
      nextdata_n_q  <= nextdata_n_d;
      key_valid_q   <= key_valid_d;
      key_code_q    <= key_code_d;
      key_release_q <= key_release_d;
      key_ext_q     <= key_ext_d;
      press_count_q <= press_count_d;
      held_valid_q  <= held_valid_d;
      held_code_q   <= held_code_d;
      held_ext_q    <= held_ext_d;
      ovf_q         <= ovf_d;
    end
  end

  assign kbd_nextdata_n = nextdata_n_q;
  assign key_valid      = key_valid_q;
  assign key_code       = key_code_q;
  assign key_release    = key_release_q;
  assign key_ext        = key_ext_q;
  assign press_count    = press_count_q;
  assign held_valid     = held_valid_q;
  assign held_code      = held_code_q;
  assign ovf_sticky     = ovf_q;

endmodule

// File: tb/tb_ps2_kbd_ctrl.sv
// Directed bench for ps2_kbd_ctrl: one filtered and one unfiltered instance
// share stimulus; each task checks its scenario inline.
module tb_ps2_kbd_ctrl;

  logic       clk;
  logic       rst;
  logic [7:0] kbd_data;
  logic       kbd_ready;
  logic       kbd_overflow;
  logic       clr_ovf;

  logic       kbd_nextdata_n, key_valid, key_release, key_ext, held_valid, ovf_sticky;
  logic [7:0] key_code, press_count, held_code;

  logic       nd_nf, kv_nf, rel_nf, ext_nf, hv_nf, ovf_nf;
  logic [7:0] code_nf, pc_nf, hc_nf;

  int n_checks = 0;
  int n_fail   = 0;
  int kv_cnt   = 0;
  int kv_cnt_nf = 0;
  int nd_cnt   = 0;

  ps2_kbd_ctrl #(.TYPEMATIC_FILTER(1'b1)) dut (
    .clk(clk), .rst(rst), .kbd_data(kbd_data), .kbd_ready(kbd_ready),
    .kbd_overflow(kbd_overflow), .clr_ovf(clr_ovf),
    .kbd_nextdata_n(kbd_nextdata_n), .key_valid(key_valid), .key_code(key_code),
    .key_release(key_release), .key_ext(key_ext), .press_count(press_count),
    .held_valid(held_valid), .held_code(held_code), .ovf_sticky(ovf_sticky)
  );

  ps2_kbd_ctrl #(.TYPEMATIC_FILTER(1'b0)) dut_nf (
    .clk(clk), .rst(rst), .kbd_data(kbd_data), .kbd_ready(kbd_ready),
    .kbd_overflow(kbd_overflow), .clr_ovf(clr_ovf),
    .kbd_nextdata_n(nd_nf), .key_valid(kv_nf), .key_code(code_nf),
    .key_release(rel_nf), .key_ext(ext_nf), .press_count(pc_nf),
    .held_valid(hv_nf), .held_code(hc_nf), .ovf_sticky(ovf_nf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (key_valid)       kv_cnt++;
    if (kv_nf)           kv_cnt_nf++;
    if (!kbd_nextdata_n) nd_cnt++;
  end

  // Starts at a negedge with the controller idle; ends at the negedge of N+3.
  task automatic send_byte(input logic [7:0] b);
    kbd_data  = b;
    kbd_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    kbd_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    kbd_ready = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    kbd_ready = 1'b0;
    kbd_data = 8'h00;
    kbd_overflow = 1'b1;
    clr_ovf = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({kbd_nextdata_n, key_valid, key_release, key_ext, held_valid, ovf_sticky} !== 6'b100000) begin
      n_fail++;
      $display("FAIL reset_flags: got %b expected 100000",
               {kbd_nextdata_n, key_valid, key_release, key_ext, held_valid, ovf_sticky});
    end
    n_checks++;
    if ({key_code, press_count, held_code} !== 24'h0) begin
      n_fail++;
      $display("FAIL reset_values: got %h expected 000000", {key_code, press_count, held_code});
    end
    kbd_overflow = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({kbd_nextdata_n, key_valid, ovf_sticky} !== 3'b100) begin
      n_fail++;
      $display("FAIL reset_release_idle: got %b expected 100", {kbd_nextdata_n, key_valid, ovf_sticky});
    end
  endtask

  task automatic test_make_break();
    int kv0;
    do_reset();
    kv0 = kv_cnt;
    send_byte(8'h1C);
    n_checks++;
    if ({key_valid, key_release, key_ext, key_code} !== {3'b100, 8'h1C}) begin
      n_fail++;
      $display("FAIL make_event: got %h expected %h", {key_valid, key_release, key_ext, key_code}, {3'b100, 8'h1C});
    end
    n_checks++;
    if ({held_valid, held_code, press_count} !== {1'b1, 8'h1C, 8'h01}) begin
      n_fail++;
      $display("FAIL make_held: got %h expected %h", {held_valid, held_code, press_count}, {1'b1, 8'h1C, 8'h01});
    end
    send_byte(8'hF0);
    n_checks++;
    if (key_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL prefix_no_event: got %b expected 0", key_valid);
    end
    send_byte(8'h1C);
    n_checks++;
    if ({key_valid, key_release, key_ext, key_code} !== {3'b110, 8'h1C}) begin
      n_fail++;
      $display("FAIL break_event: got %h expected %h", {key_valid, key_release, key_ext, key_code}, {3'b110, 8'h1C});
    end
    n_checks++;
    if ({held_valid, press_count} !== {1'b0, 8'h01}) begin
      n_fail++;
      $display("FAIL break_held: got %h expected %h", {held_valid, press_count}, {1'b0, 8'h01});
    end
    @(negedge clk);
    n_checks++;
    if (kv_cnt - kv0 !== 2) begin
      n_fail++;
      $display("FAIL make_break_pulses: got %0d expected 2", kv_cnt - kv0);
    end
  endtask

  task automatic test_typematic();
    int kv0, kvn0;
    do_reset();
    kv0 = kv_cnt;
    kvn0 = kv_cnt_nf;
    send_byte(8'h1C);
    send_byte(8'h1C);
    send_byte(8'h1C);
    n_checks++;
    if ({key_valid, key_code} !== {1'b0, 8'h1C}) begin
      n_fail++;
      $display("FAIL typematic_suppressed: got %h expected %h", {key_valid, key_code}, {1'b0, 8'h1C});
    end
    @(negedge clk);
    n_checks++;
    if (kv_cnt - kv0 !== 1 || press_count !== 8'd1) begin
      n_fail++;
      $display("FAIL typematic_filter_on: events %0d count %0d expected 1 1", kv_cnt - kv0, press_count);
    end
    n_checks++;
    if (kv_cnt_nf - kvn0 !== 3 || pc_nf !== 8'd3) begin
      n_fail++;
      $display("FAIL typematic_filter_off: events %0d count %0d expected 3 3", kv_cnt_nf - kvn0, pc_nf);
    end
  endtask

  task automatic test_extended();
    do_reset();
    send_byte(8'hE0);
    send_byte(8'h75);
    n_checks++;
    if ({key_valid, key_release, key_ext, key_code, held_valid} !== {3'b101, 8'h75, 1'b1}) begin
      n_fail++;
      $display("FAIL ext_make: got %h expected %h", {key_valid, key_release, key_ext, key_code, held_valid}, {3'b101, 8'h75, 1'b1});
    end
    send_byte(8'hE0);
    send_byte(8'hF0);
    send_byte(8'h75);
    n_checks++;
    if ({key_valid, key_release, key_ext, key_code, held_valid} !== {3'b111, 8'h75, 1'b0}) begin
      n_fail++;
      $display("FAIL ext_break: got %h expected %h", {key_valid, key_release, key_ext, key_code, held_valid}, {3'b111, 8'h75, 1'b0});
    end
  endtask

  task automatic test_latency();
    int nd0;
    do_reset();
    nd0 = nd_cnt;
    kbd_data = 8'h5A;
    kbd_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    n_checks++;
    if ({kbd_nextdata_n, key_valid} !== 2'b00) begin
      n_fail++;
      $display("FAIL latency_n1: got %b expected 00", {kbd_nextdata_n, key_valid});
    end
    kbd_ready = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({kbd_nextdata_n, key_valid} !== 2'b10) begin
      n_fail++;
      $display("FAIL latency_n2: got %b expected 10", {kbd_nextdata_n, key_valid});
    end
    @(negedge clk);
    n_checks++;
    if ({kbd_nextdata_n, key_valid, key_code} !== {2'b11, 8'h5A}) begin
      n_fail++;
      $display("FAIL latency_n3: got %h expected %h", {kbd_nextdata_n, key_valid, key_code}, {2'b11, 8'h5A});
    end
    @(negedge clk);
    n_checks++;
    if ({kbd_nextdata_n, key_valid, key_code} !== {2'b10, 8'h5A} || nd_cnt - nd0 !== 1) begin
      n_fail++;
      $display("FAIL latency_n4: got %h pops %0d expected %h pops 1",
               {kbd_nextdata_n, key_valid, key_code}, nd_cnt - nd0, {2'b10, 8'h5A});
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] seq [3];
    int kv0, nd0;
    seq[0] = 8'h15;
    seq[1] = 8'h1D;
    seq[2] = 8'h24;
    do_reset();
    kv0 = kv_cnt;
    nd0 = nd_cnt;
    for (int i = 0; i < 3; i++) begin
      kbd_data  = seq[i];
      kbd_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      @(negedge clk);
      @(negedge clk);
      n_checks++;
      if ({key_valid, key_code} !== {1'b1, seq[i]}) begin
        n_fail++;
        $display("FAIL b2b_event%0d: got %h expected %h", i, {key_valid, key_code}, {1'b1, seq[i]});
      end
    end
    kbd_ready = 1'b0;
    @(negedge clk);
    n_checks++;
    if (kv_cnt - kv0 !== 3 || nd_cnt - nd0 !== 3 || press_count !== 8'd3) begin
      n_fail++;
      $display("FAIL b2b_totals: events %0d pops %0d count %0d expected 3 3 3",
               kv_cnt - kv0, nd_cnt - nd0, press_count);
    end
  endtask

  task automatic test_filler();
    do_reset();
    send_byte(8'hF0);
    send_byte(8'h00);
    n_checks++;
    if (key_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL filler_no_event: got %b expected 0", key_valid);
    end
    send_byte(8'h2B);
    n_checks++;
    if ({key_valid, key_release, key_ext, key_code} !== {3'b100, 8'h2B}) begin
      n_fail++;
      $display("FAIL filler_clears_brk: got %h expected %h", {key_valid, key_release, key_ext, key_code}, {3'b100, 8'h2B});
    end
    send_byte(8'hE0);
    send_byte(8'hFF);
    send_byte(8'h34);
    n_checks++;
    if ({key_valid, key_release, key_ext, key_code} !== {3'b100, 8'h34}) begin
      n_fail++;
      $display("FAIL filler_clears_ext: got %h expected %h", {key_valid, key_release, key_ext, key_code}, {3'b100, 8'h34});
    end
  endtask

  task automatic test_nonmatch_break();
    do_reset();
    send_byte(8'h1C);
    send_byte(8'hF0);
    send_byte(8'h32);
    n_checks++;
    if ({key_valid, key_release, key_ext, key_code} !== {3'b110, 8'h32}) begin
      n_fail++;
      $display("FAIL nonmatch_break_event: got %h expected %h", {key_valid, key_release, key_ext, key_code}, {3'b110, 8'h32});
    end
    n_checks++;
    if ({held_valid, held_code, press_count} !== {1'b1, 8'h1C, 8'h01}) begin
      n_fail++;
      $display("FAIL nonmatch_break_held: got %h expected %h", {held_valid, held_code, press_count}, {1'b1, 8'h1C, 8'h01});
    end
  endtask

  task automatic test_wrap_and_ovf();
    int kv0;
    logic [7:0] code;
    logic       ext;
    do_reset();
    kv0 = kv_cnt;
    for (int i = 0; i < 256; i++) begin
      ext  = (i >= 128);
      code = 8'((i % 128) + 1);
      if (ext) send_byte(8'hE0);
      send_byte(code);
      if (i == 0 || i == 254 || i == 255) begin
        n_checks++;
        if ({key_valid, key_release, key_ext, key_code, press_count} !== {2'b10, ext, code, 8'((i + 1) % 256)}) begin
          n_fail++;
          $display("FAIL wrap_make%0d: got %h expected %h", i,
                   {key_valid, key_release, key_ext, key_code, press_count}, {2'b10, ext, code, 8'((i + 1) % 256)});
        end
      end
      if (ext) send_byte(8'hE0);
      send_byte(8'hF0);
      send_byte(code);
    end
    @(negedge clk);
    n_checks++;
    if (kv_cnt - kv0 !== 512 || press_count !== 8'h00 || held_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL wrap_totals: events %0d count %h held %b expected 512 00 0",
               kv_cnt - kv0, press_count, held_valid);
    end
    kbd_overflow = 1'b1;
    @(negedge clk);
    kbd_overflow = 1'b0;
    @(negedge clk);
    n_checks++;
    if (ovf_sticky !== 1'b1) begin
      n_fail++;
      $display("FAIL ovf_latched: got %b expected 1", ovf_sticky);
    end
    clr_ovf = 1'b1;
    @(negedge clk);
    clr_ovf = 1'b0;
    n_checks++;
    if (ovf_sticky !== 1'b0) begin
      n_fail++;
      $display("FAIL ovf_cleared: got %b expected 0", ovf_sticky);
    end
    kbd_overflow = 1'b1;
    clr_ovf = 1'b1;
    @(negedge clk);
    kbd_overflow = 1'b0;
    clr_ovf = 1'b0;
    n_checks++;
    if (ovf_sticky !== 1'b1) begin
      n_fail++;
      $display("FAIL ovf_set_wins: got %b expected 1", ovf_sticky);
    end
  endtask

  task automatic test_reset_mid();
    int kv0;
    do_reset();
    send_byte(8'hF0);
    kv0 = kv_cnt;
    kbd_data  = 8'h1C;
    kbd_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    kbd_ready = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    n_checks++;
    if ({kbd_nextdata_n, key_valid, press_count} !== {2'b10, 8'h00}) begin
      n_fail++;
      $display("FAIL reset_mid_state: got %h expected %h", {kbd_nextdata_n, key_valid, press_count}, {2'b10, 8'h00});
    end
    send_byte(8'h1B);
    n_checks++;
    if ({key_valid, key_release, key_ext, key_code} !== {3'b100, 8'h1B}) begin
      n_fail++;
      $display("FAIL reset_mid_event: got %h expected %h", {key_valid, key_release, key_ext, key_code}, {3'b100, 8'h1B});
    end
    n_checks++;
    if ({held_valid, held_code, press_count} !== {1'b1, 8'h1B, 8'h01} || kv_cnt - kv0 !== 0) begin
      n_fail++;
      $display("FAIL reset_mid_held: got %h prior events %0d expected %h 0",
               {held_valid, held_code, press_count}, kv_cnt - kv0, {1'b1, 8'h1B, 8'h01});
    end
  endtask

  initial begin
    test_reset();
    test_make_break();
    test_typematic();
    test_extended();
    test_latency();
    test_back_to_back();
    test_filler();
    test_nonmatch_break();
    test_wrap_and_ovf();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ps2_kbd_ctrl.md
PS2_KBD_CTRL -- requirements
Module: ps2_kbd_ctrl

Interface
REQ-001 Parameter TYPEMATIC_FILTER, default 1: when 1, repeated make codes for the currently held key SHALL be suppressed.
REQ-002 Port clk, input, 1: system clock; all state SHALL update on its rising edge.
REQ-003 Port rst, input, 1: reset, synchronous and active-high.
REQ-004 Port kbd_data, input, 8: scancode byte from the ps2_keyboard FIFO head.
REQ-005 Port kbd_ready, input, 1: FIFO non-empty.
REQ-006 Port kbd_overflow, input, 1: FIFO overflow indication.
REQ-007 Port kbd_nextdata_n, output, 1: active-low FIFO pop strobe, registered.
REQ-008 Port key_valid, output, 1: one-cycle key event strobe.
REQ-009 Port key_code, output, 8: final scancode of the event.
REQ-010 Port key_release, output, 1: event is a break (F0-prefixed).
REQ-011 Port key_ext, output, 1: event is extended (E0-prefixed).
REQ-012 Port press_count, output, 8: count of emitted make events.
REQ-013 Port held_valid / held_code, output, 1 / 8: a key is currently held / its code.
REQ-014 Port ovf_sticky, output, 1: latched overflow flag.
REQ-015 Port clr_ovf, input, 1: clears ovf_sticky.

Function
REQ-016 FSM states SHALL be IDLE, ACK, DECODE; reset state IDLE.
REQ-017 IDLE with kbd_ready=1: SHALL capture kbd_data into the byte register and go to ACK; otherwise it SHALL stay in IDLE.
REQ-018 ACK: kbd_nextdata_n SHALL be 0 for exactly this one cycle; the FSM SHALL then go to DECODE unconditionally.
REQ-019 DECODE: kbd_nextdata_n SHALL be 1; the captured byte SHALL be decoded; the FSM SHALL then return to IDLE, giving a one-cycle gap so kbd_ready can update.
REQ-020 Decoding 0xF0: brk_flag SHALL be set and no event emitted; a repeated 0xF0 SHALL keep brk_flag set.
REQ-021 Decoding 0xE0: ext_flag SHALL be set and no event emitted.
REQ-022 Decoding 0x00 or 0xFF: the byte SHALL be discarded, both flags cleared, and no event emitted.
REQ-023 Decoding any other byte: an event SHALL be formed with code=byte, release=brk_flag, ext=ext_flag, and both flags cleared.
REQ-024 Latency: if kbd_ready is sampled in cycle N, kbd_nextdata_n SHALL be low in N+1, decode SHALL occur in N+2, and key_valid SHALL be high in N+3 for one cycle. key_code/key_release/key_ext SHALL hold until the next event.
REQ-025 Make event with TYPEMATIC_FILTER=1 and held_valid=1 and {ext,code} equal to the held key: the event SHALL be suppressed (no key_valid, no count change).
REQ-026 Emitted make event: held_code SHALL be set to the code, held_ext to ext, held_valid to 1, and press_count incremented modulo 256 (255 wraps to 0).
REQ-027 Break event matching the held {ext,code}: held_valid SHALL clear. A non-matching break SHALL be emitted but SHALL NOT change held state.
REQ-028 ovf_sticky SHALL set on any cycle with kbd_overflow=1 and clear on clr_ovf=1; if both occur in the same cycle, set SHALL win.
REQ-029 Maximum throughput SHALL be one byte per 3 cycles; back-to-back kbd_ready SHALL be serviced without gaps beyond that.

Reset
REQ-030 While rst=1: state=IDLE, kbd_nextdata_n=1, key_valid=0, key_code=0x00, key_release=0, key_ext=0, press_count=0, held_valid=0, held_code=0x00, ovf_sticky=0, and brk/ext flags cleared.
REQ-031 rst asserted mid-sequence (ACK or DECODE): any pending event and prefix SHALL be dropped, and the controller SHALL resume in IDLE on the first cycle after rst deasserts.

Verification
REQ-032 Bytes 1C, F0, 1C: a make event for 1C (press_count=1, held_code=1C) SHALL be followed by a release event for 1C (held_valid=0); key_valid SHALL pulse exactly twice.
REQ-033 Bytes 1C, 1C, 1C with TYPEMATIC_FILTER=1: exactly one key_valid and press_count=1; with filter=0: three events and press_count=3.
REQ-034 Bytes E0, 75, E0, F0, 75: the make event SHALL have ext=1, release=0, and the break event ext=1, release=1.
REQ-035 kbd_ready held at 1 for one byte: kbd_nextdata_n SHALL be low exactly one cycle, at N+1, and key_valid SHALL pulse at N+3.
REQ-036 256 distinct make/break pairs: press_count SHALL wrap to 0x00; kbd_overflow and clr_ovf in the same cycle SHALL leave ovf_sticky=1.
REQ-037 Bytes F0 then rst pulse then 1B: the 1B event SHALL have release=0 and held_code=1B.
